// File: rtl/k580_inta_seq.sv
// Interrupt-acknowledge sequencer between an 8080-class CPU and a k580 PIC.
// Turns the CPU's three INTA reads into clean PIC acknowledge pulses, returns
// the PIC bytes, and flushes missing pulses so the PIC's 3-pulse counter
// always ends a sequence in step with the CPU.
module k580_inta_seq #(
  parameter int unsigned INTA_LOW = 2,
  parameter int unsigned GAP      = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_inte_i,
  input  logic       cpu_intack_i,
  input  logic       cpu_dbin_i,
  input  logic       pic_intr_i,
  input  logic [7:0] pic_data_i,
  output logic       cpu_int_o,
  output logic       pic_inta_n_o,
  output logic [7:0] cpu_data_o,
  output logic       cpu_data_oe_o,
  output logic       busy_o,
  output logic [1:0] byte_idx_o,
  output logic       flushed_o
);

  localparam int unsigned CW = 4;
  localparam int unsigned WW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HOLD,
    S_GAP,
    S_WAIT,
    S_FLUSH_LOW,
    S_FLUSH_HIGH
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic            dbin_q;
  logic [7:0]      cpu_data_q, cpu_data_d;
  logic            pic_inta_n_q, pic_inta_n_d;
  logic            cpu_data_oe_q, cpu_data_oe_d;
  logic            busy_q, busy_d;
  logic            flushed_q, flushed_d;
  logic            cpu_int_q, cpu_int_d;

  logic            dbin_rise_c;
  logic            start_c;
  logic            foreign_c;
  logic            last_low_c;
  logic            last_gap_c;
  logic [1:0]      byte_inc_c;

  // Read-strobe edge classification and phase-end detection
  assign dbin_rise_c = cpu_dbin_i & ~dbin_q;
  assign start_c     = dbin_rise_c & cpu_intack_i;
  assign foreign_c   = dbin_rise_c & ~cpu_intack_i;
  assign last_low_c  = (cnt_q == CW'(INTA_LOW - 1));
  assign last_gap_c  = (cnt_q == CW'(GAP - 1));
  assign byte_inc_c  = (byte_idx_q == 2'd3) ? 2'd3 : byte_idx_q + 2'd1;

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wdog_q        <= '0;
      byte_idx_q    <= '0;
      dbin_q        <= 1'b0;
      cpu_data_q    <= 8'h00;
      pic_inta_n_q  <= 1'b1;
      cpu_data_oe_q <= 1'b0;
      busy_q        <= 1'b0;
      flushed_q     <= 1'b0;
      cpu_int_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wdog_q        <= wdog_d;
      byte_idx_q    <= byte_idx_d;
      dbin_q        <= cpu_dbin_i;
      cpu_data_q    <= cpu_data_d;
      pic_inta_n_q  <= pic_inta_n_d;
      cpu_data_oe_q <= cpu_data_oe_d;
      busy_q        <= busy_d;
      flushed_q     <= flushed_d;
      cpu_int_q     <= cpu_int_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    byte_idx_d = byte_idx_q;
    cpu_data_d = cpu_data_q;
    flushed_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        wdog_d = '0;
        if (start_c) state_d = S_LOW;
      end
      S_LOW: begin
        cpu_data_d = pic_data_i;
        if (last_low_c) begin
          cnt_d = '0;
          // A read that already ended skips HOLD so the pulse is exactly INTA_LOW
          if (cpu_dbin_i) begin
            state_d = S_HOLD;
          end else begin
            state_d    = S_GAP;
            byte_idx_d = byte_inc_c;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (!cpu_dbin_i) begin
          state_d    = S_GAP;
          byte_idx_d = byte_inc_c;
          cnt_d      = '0;
        end
      end
      S_GAP: begin
        if (last_gap_c) begin
          cnt_d  = '0;
          wdog_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            state_d    = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT: begin
        if (start_c) begin
          state_d = S_LOW;
          wdog_d  = '0;
          cnt_d   = '0;
        end else if (foreign_c || (wdog_q == WW'(TIMEOUT - 1))) begin
          state_d = S_FLUSH_LOW;
          cnt_d   = '0;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_FLUSH_LOW: begin
        if (last_low_c) begin
          state_d    = S_FLUSH_HIGH;
          byte_idx_d = byte_inc_c;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FLUSH_HIGH: begin
        if (last_gap_c) begin
          cnt_d = '0;
          if (byte_idx_q == 2'd3) begin
            byte_idx_d = 2'd0;
            flushed_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            state_d = S_FLUSH_LOW;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pic_inta_n_d  = !(state_d inside {S_LOW, S_HOLD, S_FLUSH_LOW});
    cpu_data_oe_d = (state_d inside {S_LOW, S_HOLD});
    busy_d        = (state_d != S_IDLE);
    cpu_int_d     = pic_intr_i & cpu_inte_i & (state_d == S_IDLE);
  end

  assign cpu_int_o     = cpu_int_q;
  assign pic_inta_n_o  = pic_inta_n_q;
  assign cpu_data_o    = cpu_data_q;
  assign cpu_data_oe_o = cpu_data_oe_q;
  assign busy_o        = busy_q;
  assign byte_idx_o    = byte_idx_q;
  assign flushed_o     = flushed_q;

endmodule
